// File: rtl/mouse_cursor_tracker_pkg.sv
// Shared definitions for the mouse cursor tracker.
// Holds the controller state enumeration, the bit positions inside the
// PS/2 mouse header byte and the ACK byte that a mouse sends after a command.
package mouse_cursor_tracker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BYTE1,
    BYTE2,
    UPDATE,
    ERASE,
    DRAW
  } state_t;

  localparam int HDR_YOVF = 7;
  localparam int HDR_XOVF = 6;
  localparam int HDR_YSGN = 5;
  localparam int HDR_XSGN = 4;
  localparam int HDR_SYNC = 3;

  localparam logic [7:0] PS2_ACK = 8'hFA;

endpackage

// File: rtl/mouse_cursor_tracker_ps2_packet_assembler.sv
// Assembles three-byte PS/2 mouse packets from a byte strobe stream.
// Ports:
//   clock, reset       : system clock, asynchronous active-high reset
//   rx_data, rx_valid  : received byte and its one-cycle strobe
//   hold               : downstream busy; bytes go to a one-entry skid register
//   header, dx, dy     : fields of the last assembled packet
//   pkt_valid          : one-cycle pulse in the cycle the third byte is taken
module ps2_packet_assembler
  import mouse_cursor_tracker_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       hold,
  output logic [7:0] header,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic       pkt_valid
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          skid_vld_q, skid_vld_d;
  logic [7:0]    skid_q, skid_d;
  logic [7:0]    header_q, header_d;
  logic [7:0]    dx_q, dx_d;
  logic [7:0]    dy_q, dy_d;
  logic          byte_vld;
  logic [7:0]    byte_in;

  always_comb begin
    // A parked byte is older than anything on rx_data, so it goes first.
    byte_in  = skid_vld_q ? skid_q : rx_data;
    byte_vld = !hold && (skid_vld_q || rx_valid);

    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (hold) begin
      if (rx_valid) begin
        skid_d     = rx_data;
        skid_vld_d = 1'b1;
      end
    end else if (skid_vld_q) begin
      // Skid drains this cycle; a byte arriving alongside takes its place.
      skid_d     = rx_data;
      skid_vld_d = rx_valid;
    end

    state_d   = state_q;
    cnt_d     = cnt_q;
    header_d  = header_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    pkt_valid = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (byte_vld && byte_in[HDR_SYNC] && (byte_in != PS2_ACK)) begin
          header_d = byte_in;
          state_d  = BYTE1;
        end
      end
      BYTE1, BYTE2: begin
        if (byte_vld) begin
          cnt_d = '0;
          if (state_q == BYTE1) begin
            dx_d    = byte_in;
            state_d = BYTE2;
          end else begin
            dy_d      = byte_in;
            pkt_valid = 1'b1;
            state_d   = IDLE;
          end
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  always_ff @(posedge clock) begin
    skid_q   <= skid_d;
    header_q <= header_d;
    dx_q     <= dx_d;
    dy_q     <= dy_d;
  end

  assign header = header_q;
  assign dx     = dx_q;
  assign dy     = dy_q;

endmodule

// File: rtl/mouse_cursor_tracker.sv
// Tracks a PS/2 mouse cursor on a bitmap display and plots it.
// Each accepted packet moves the cursor (clamped to the screen), then the old
// pixel is erased with BG_COLOUR and the new pixel drawn in the latched colour.
// Ports:
//   clock, reset        : system clock, asynchronous active-high reset
//   rx_data, rx_valid   : PS/2 byte stream from the receiver
//   colour              : cursor colour, sampled when a packet is applied
//   x_out, y_out, c_out : pixel to write; plot is the write strobe
//   buttons             : {middle, right, left} from the last packet
//   moved               : one-cycle pulse per accepted packet
module mouse_cursor_tracker
  import mouse_cursor_tracker_pkg::*;
#(
  parameter int             X_W       = 8,
  parameter int             Y_W       = 7,
  parameter int             C_W       = 3,
  parameter int             X_MAX     = 159,
  parameter int             Y_MAX     = 119,
  parameter int             X_INIT    = 80,
  parameter int             Y_INIT    = 60,
  parameter int             SHIFT     = 0,
  parameter logic [C_W-1:0] BG_COLOUR = '0,
  parameter int             TIMEOUT   = 50000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  input  logic [C_W-1:0] colour,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [C_W-1:0] c_out,
  output logic           plot,
  output logic [2:0]     buttons,
  output logic           moved
);

  localparam int XY_W = (X_W > Y_W) ? X_W : Y_W;
  localparam int SW   = ((XY_W > 9) ? XY_W : 9) + 2;
  localparam logic signed [SW-1:0] X_MAX_S = SW'(X_MAX);
  localparam logic signed [SW-1:0] Y_MAX_S = SW'(Y_MAX);

  // 9-bit two's complement delta, zeroed on overflow, then scaled down.
  // >>> on a signed value floors toward negative infinity.
  function automatic logic signed [8:0] delta(input logic sgn, input logic ovf,
                                              input logic [7:0] mag);
    logic signed [8:0] d;
    d = ovf ? 9'sd0 : $signed({sgn, mag});
    return d >>> SHIFT;
  endfunction

  function automatic logic [X_W-1:0] clamp_x(input logic signed [SW-1:0] v);
    if (v < 0)       return '0;
    if (v > X_MAX_S) return X_W'(X_MAX);
    return v[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] clamp_y(input logic signed [SW-1:0] v);
    if (v < 0)       return '0;
    if (v > Y_MAX_S) return Y_W'(Y_MAX);
    return v[Y_W-1:0];
  endfunction

  logic [7:0] header, dx, dy;
  logic       pkt_valid;
  logic       hold;

  state_t          state_q, state_d;
  logic [X_W-1:0]  x_q, x_d, nx_q, nx_d, x_out_q, x_out_d;
  logic [Y_W-1:0]  y_q, y_d, ny_q, ny_d, y_out_q, y_out_d;
  logic [C_W-1:0]  col_q, col_d, c_out_q, c_out_d;
  logic            plot_q, plot_d, moved_q, moved_d;
  logic [2:0]      buttons_q, buttons_d;
  logic signed [8:0]    dx_s, dy_s;
  logic signed [SW-1:0] sum_x, sum_y;

  // Bytes arriving while a pixel pair is in flight are parked, not lost.
  assign hold = (state_q == UPDATE) || (state_q == ERASE) || (state_q == DRAW);

  ps2_packet_assembler #(
    .TIMEOUT (TIMEOUT)
  ) u_asm (
    .clock     (clock),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .hold      (hold),
    .header    (header),
    .dx        (dx),
    .dy        (dy),
    .pkt_valid (pkt_valid)
  );

  always_comb begin
    dx_s  = delta(header[HDR_XSGN], header[HDR_XOVF], dx);
    dy_s  = delta(header[HDR_YSGN], header[HDR_YOVF], dy);
    // PS/2 +y is up while screen rows grow downward, hence the subtraction.
    sum_x = $signed({{(SW - X_W){1'b0}}, x_q}) + $signed({{(SW - 9){dx_s[8]}}, dx_s});
    sum_y = $signed({{(SW - Y_W){1'b0}}, y_q}) - $signed({{(SW - 9){dy_s[8]}}, dy_s});

    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    nx_d      = nx_q;
    ny_d      = ny_q;
    col_d     = col_q;
    x_out_d   = x_out_q;
    y_out_d   = y_out_q;
    c_out_d   = c_out_q;
    buttons_d = buttons_q;
    plot_d    = 1'b0;
    moved_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pkt_valid) begin
          state_d = UPDATE;
          moved_d = 1'b1;
        end
      end
      UPDATE: begin
        state_d   = ERASE;
        nx_d      = clamp_x(sum_x);
        ny_d      = clamp_y(sum_y);
        col_d     = colour;
        buttons_d = header[2:0];
        plot_d    = 1'b1;
        x_out_d   = x_q;
        y_out_d   = y_q;
        c_out_d   = BG_COLOUR;
      end
      ERASE: begin
        state_d = DRAW;
        plot_d  = 1'b1;
        x_out_d = nx_q;
        y_out_d = ny_q;
        c_out_d = col_q;
      end
      DRAW: begin
        state_d = IDLE;
        x_d     = nx_q;
        y_d     = ny_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= X_W'(X_INIT);
      y_q       <= Y_W'(Y_INIT);
      x_out_q   <= '0;
      y_out_q   <= '0;
      c_out_q   <= '0;
      plot_q    <= 1'b0;
      buttons_q <= '0;
      moved_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      x_out_q   <= x_out_d;
      y_out_q   <= y_out_d;
      c_out_q   <= c_out_d;
      plot_q    <= plot_d;
      buttons_q <= buttons_d;
      moved_q   <= moved_d;
    end
  end

  always_ff @(posedge clock) begin
    nx_q  <= nx_d;
    ny_q  <= ny_d;
    col_q <= col_d;
  end

  assign x_out   = x_out_q;
  assign y_out   = y_out_q;
  assign c_out   = c_out_q;
  assign plot    = plot_q;
  assign buttons = buttons_q;
  assign moved   = moved_q;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Bench for mouse_cursor_tracker: two instances (SHIFT=0 and SHIFT=1) share one
// byte stream; a packet-level model predicts each erase/draw pair.
module tb_mouse_cursor_tracker;

  localparam int TMO = 20;
  localparam int XMX = 159;
  localparam int YMX = 119;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] colour;

  wire [1:0][7:0] xo;
  wire [1:0][6:0] yo;
  wire [1:0][2:0] co;
  wire [1:0][2:0] bo;
  wire [1:0]      po;
  wire [1:0]      mo;

  int compared   = 0;
  int mismatched = 0;
  int mx[2], my[2];
  int sh[2] = '{0, 1};
  int plot_cnt[2]  = '{0, 0};
  int moved_cnt[2] = '{0, 0};
  int exp_plots = 0;
  int exp_moved = 0;
  logic [7:0] rh, rdx, rdy;

  always #5 clock = ~clock;

  mouse_cursor_tracker #(.SHIFT(0), .TIMEOUT(TMO)) dut0 (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .colour(colour), .x_out(xo[0]), .y_out(yo[0]), .c_out(co[0]),
    .plot(po[0]), .buttons(bo[0]), .moved(mo[0])
  );

  mouse_cursor_tracker #(.SHIFT(1), .TIMEOUT(TMO)) dut1 (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .colour(colour), .x_out(xo[1]), .y_out(yo[1]), .c_out(co[1]),
    .plot(po[1]), .buttons(bo[1]), .moved(mo[1])
  );

  always @(negedge clock) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if (po[k] === 1'b1) plot_cnt[k]++;
        if (mo[k] === 1'b1) moved_cnt[k]++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  // Signed delta from sign bit + magnitude, zero on overflow, floor-divided by 2^s.
  function automatic int mv(input logic [7:0] b, input logic sgn, input logic ovf, input int s);
    int d, p, q;
    if (ovf) return 0;
    d = sgn ? int'(b) - 256 : int'(b);
    p = 1 << s;
    q = d / p;
    if (d < 0 && (d % p) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_rst_plot", i), po[i], 0);
      chk($sformatf("d%0d_rst_x", i), xo[i], 0);
      chk($sformatf("d%0d_rst_y", i), yo[i], 0);
      chk($sformatf("d%0d_rst_c", i), co[i], 0);
      chk($sformatf("d%0d_rst_btn", i), bo[i], 0);
      chk($sformatf("d%0d_rst_moved", i), mo[i], 0);
      mx[i] = 80;
      my[i] = 60;
    end
    tick(2);
    reset = 1'b0;
  endtask

  // Sends one packet and checks the UPDATE/ERASE/DRAW sequence cycle by cycle.
  // n_extra bytes (e0 in UPDATE, e1 in ERASE) land in the skid register;
  // hdr_in_skid means the header was already parked by the previous call.
  task automatic do_packet(input logic [7:0] h, input logic [7:0] dx, input logic [7:0] dy,
                           input logic [2:0] col, input int gap, input int n_extra,
                           input logic [7:0] e0, input logic [7:0] e1, input bit hdr_in_skid);
    int nx[2], ny[2];
    colour = col;
    if (hdr_in_skid) tick(1);
    else begin
      send_byte(h);
      tick(gap);
    end
    send_byte(dx);
    tick(gap);
    send_byte(dy);
    for (int i = 0; i < 2; i++) begin
      nx[i] = clampi(mx[i] + mv(dx, h[4], h[6], sh[i]), XMX);
      ny[i] = clampi(my[i] - mv(dy, h[5], h[7], sh[i]), YMX);
      chk($sformatf("d%0d_upd_moved", i), mo[i], 1);
      chk($sformatf("d%0d_upd_plot", i), po[i], 0);
    end
    if (n_extra >= 1) begin
      rx_data  = e0;
      rx_valid = 1'b1;
    end
    tick(1);
    rx_valid = 1'b0;
    colour   = ~col;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_erase_plot", i), po[i], 1);
      chk($sformatf("d%0d_erase_x", i), xo[i], mx[i]);
      chk($sformatf("d%0d_erase_y", i), yo[i], my[i]);
      chk($sformatf("d%0d_erase_c", i), co[i], 0);
      chk($sformatf("d%0d_buttons", i), bo[i], h[2:0]);
      chk($sformatf("d%0d_erase_moved", i), mo[i], 0);
    end
    if (n_extra >= 2) begin
      rx_data  = e1;
      rx_valid = 1'b1;
    end
    tick(1);
    rx_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_draw_plot", i), po[i], 1);
      chk($sformatf("d%0d_draw_x", i), xo[i], nx[i]);
      chk($sformatf("d%0d_draw_y", i), yo[i], ny[i]);
      chk($sformatf("d%0d_draw_c", i), co[i], col);
    end
    tick(1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_after_plot", i), po[i], 0);
      chk($sformatf("d%0d_hold_x", i), xo[i], nx[i]);
      chk($sformatf("d%0d_hold_c", i), co[i], col);
      mx[i] = nx[i];
      my[i] = ny[i];
    end
    exp_plots += 2;
    exp_moved += 1;
  endtask

  initial begin
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    colour   = 3'b000;
    reset    = 1'b1;
    tick(1);
    do_reset();

    // Basic move, then clamps on both axes, then overflow with a button.
    do_packet(8'h08, 8'h05, 8'h03, 3'b010, 0, 0, 8'h00, 8'h00, 0);
    do_packet(8'h18, 8'hAE, 8'h00, 3'b001, 1, 0, 8'h00, 8'h00, 0);
    do_packet(8'h18, 8'hF6, 8'h00, 3'b011, 0, 0, 8'h00, 8'h00, 0);
    do_packet(8'h28, 8'h00, 8'h80, 3'b100, 2, 0, 8'h00, 8'h00, 0);
    do_packet(8'hC9, 8'h7F, 8'h7F, 3'b101, 0, 0, 8'h00, 8'h00, 0);

    // Random packets, headers forced to carry the sync bit and avoid the ACK value.
    for (int n = 0; n < 12; n++) begin
      rh    = 8'($urandom_range(0, 255));
      rh[3] = 1'b1;
      if (rh == 8'hFA) rh = 8'h0A;
      rdx = 8'($urandom_range(0, 255));
      rdy = 8'($urandom_range(0, 255));
      do_packet(rh, rdx, rdy, 3'($urandom_range(0, 7)), $urandom_range(0, 3), 0, 8'h00, 8'h00, 0);
    end

    // A byte during UPDATE is parked; a second during ERASE replaces it.
    do_packet(8'h08, 8'h02, 8'h01, 3'b110, 0, 1, 8'h0A, 8'h00, 0);
    do_packet(8'h0A, 8'h04, 8'h04, 3'b111, 0, 0, 8'h00, 8'h00, 1);
    do_packet(8'h08, 8'h01, 8'h01, 3'b001, 0, 2, 8'h08, 8'h09, 0);
    do_packet(8'h09, 8'h02, 8'h00, 3'b010, 0, 0, 8'h00, 8'h00, 1);

    // Gaps just short of the timeout must not abandon the packet.
    do_packet(8'h08, 8'h01, 8'h02, 3'b011, TMO - 1, 0, 8'h00, 8'h00, 0);

    // ACK and non-sync bytes dropped; a lone header is abandoned after the timeout.
    do_reset();
    send_byte(8'hFA);
    send_byte(8'h00);
    send_byte(8'h08);
    tick(TMO);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_drop_moved", i), mo[i], 0);
      chk($sformatf("d%0d_drop_plot", i), po[i], 0);
    end
    do_packet(8'h08, 8'h01, 8'h01, 3'b010, 0, 0, 8'h00, 8'h00, 0);

    // Negative odd delta exercises the floor in the scaled instance.
    do_reset();
    do_packet(8'h18, 8'hFD, 8'h00, 3'b100, 0, 0, 8'h00, 8'h00, 0);

    // Reset during ERASE kills the plot at once and restores the start position.
    colour = 3'b111;
    send_byte(8'h08);
    send_byte(8'h03);
    send_byte(8'h03);
    exp_moved += 1;
    tick(1);
    for (int i = 0; i < 2; i++) chk($sformatf("d%0d_pre_rst_plot", i), po[i], 1);
    do_reset();
    tick(5);
    for (int i = 0; i < 2; i++) chk($sformatf("d%0d_post_rst_plot", i), po[i], 0);
    do_packet(8'h08, 8'h00, 8'h00, 3'b110, 0, 0, 8'h00, 8'h00, 0);

    tick(3);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_plot_count", i), plot_cnt[i], exp_plots);
      chk($sformatf("d%0d_moved_count", i), moved_cnt[i], exp_moved);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
